// File: rtl/down_timer.sv
// Loadable down-counting timer (stop > load > count); optional periodic mode via DOWN_TIMER_AUTO_RELOAD_EN.
// Latency: cnt shows load_val one cycle after load; done pulses load_val+1 cycles after load.
// No backpressure: load/stop are sampled every edge; en pauses the count while running.
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             stop,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             done_nxt;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload, reload_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    reload_nxt = reload;
`endif
    if (stop) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (load) begin
      // Load behaves identically from IDLE, RUN (restart) and DONE.
      cnt_nxt = load_val;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      reload_nxt = load_val;
`endif
      if (load_val == '0) begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            if (cnt == WIDTH'(1)) begin
              done_nxt = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
              cnt_nxt = reload;
`else
              state_nxt = DONE;
              cnt_nxt   = '0;
`endif
            end else begin
              cnt_nxt = cnt - 1'b1;
            end
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload <= '0;
    end else begin
      reload <= reload_nxt;
    end
  end
`endif

  assign busy = (state == RUN);

endmodule
